// File: rtl/interp_lut_pkg.sv
// Shared types and helpers for the streaming interpolating lookup table.
// The stage struct is sized for the widest supported configuration; the top narrows fields on use.
package interp_lut_pkg;

    localparam int MAX_CW = 8;
    localparam int MAX_DW = 32;

    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    typedef struct packed {
        logic              valid;
        logic [MAX_CW-1:0] ch;
        logic              bypass;
        logic [MAX_DW-1:0] frac;
        logic [MAX_DW-1:0] raw;
    } stage_t;

endpackage

// File: rtl/interp_lut_stream_if.sv
// Sample stream and table-programming bus of interp_lut_stream.
// The master drives samples and table writes; the slave is the lookup pipeline.
interface interp_lut_stream_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DWIDTH     = 24,
    parameter int CW         = 1
);
    logic                  prog_we;
    logic [CW-1:0]         prog_ch;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DWIDTH-1:0]     prog_data;
    logic [DWIDTH-1:0]     din;
    logic [CW-1:0]         din_ch;
    logic                  din_bypass;
    logic                  din_valid;
    logic                  din_ready;
    logic [DWIDTH-1:0]     dout;
    logic [CW-1:0]         dout_ch;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        output prog_we, prog_ch, prog_addr, prog_data,
        output din, din_ch, din_bypass, din_valid, dout_ready,
        input  din_ready, dout, dout_ch, dout_valid
    );

    modport slave (
        input  prog_we, prog_ch, prog_addr, prog_data,
        input  din, din_ch, din_bypass, din_valid, dout_ready,
        output din_ready, dout, dout_ch, dout_valid
    );
endinterface

// File: rtl/interp_lut_dpram.sv
// Table RAM: one write port, two registered read ports sharing a read clock-enable.
// Reads sample the array before the same-edge write lands, so a colliding read returns the old entry.
module interp_lut_dpram #(
    parameter int AW = 5,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end
endmodule

// File: rtl/interp_lut_stream.sv
// Streaming multi-channel interpolating lookup table: one sample per clock, fixed latency.
// Upper din bits pick floor/ceil entries of the channel table; the fraction blends between them.
module interp_lut_stream
    import interp_lut_pkg::*;
#(
    parameter int G_ADDR_WIDTH  = 10,
    parameter int G_DWIDTH      = 24,
    parameter int G_CHANNELS    = 2,
    parameter int G_SIGNED_DATA = 0
) (
    input logic                clk,
    input logic                reset,
    interp_lut_stream_if.slave bus
);
    localparam int CW  = chan_w(G_CHANNELS);
    localparam int F   = G_DWIDTH - G_ADDR_WIDTH;
    localparam int RAW = CW + G_ADDR_WIDTH;
    localparam int PW  = G_DWIDTH + F + 2;
    localparam logic [G_ADDR_WIDTH-1:0] TOP_IDX = '1;

    logic                      advance;
    logic                      prog_en;
    logic [G_ADDR_WIDTH-1:0]   idx;
    logic [G_ADDR_WIDTH-1:0]   idx_ceil;
    logic [G_DWIDTH-1:0]       floor_q;
    logic [G_DWIDTH-1:0]       ceil_q;
    stage_t                    m1, m2, m3, m4;
    logic signed [G_DWIDTH:0]  floor2, floor3;
    logic signed [G_DWIDTH:0]  diff2;
    logic signed [PW-1:0]      prod3;
    logic [G_DWIDTH-1:0]       res4;
    logic                      dout_valid_q;
    logic [G_DWIDTH-1:0]       dout_q;
    logic [CW-1:0]             dout_ch_q;
    logic                      unused_meta;

    function automatic logic signed [G_DWIDTH:0] ext(input logic [G_DWIDTH-1:0] v);
        return (G_SIGNED_DATA != 0) ? $signed({v[G_DWIDTH-1], v}) : $signed({1'b0, v});
    endfunction

    assign advance        = !dout_valid_q || bus.dout_ready;
    assign bus.din_ready  = advance;
    assign bus.dout       = dout_q;
    assign bus.dout_ch    = dout_ch_q;
    assign bus.dout_valid = dout_valid_q;

    // The last entry has no right neighbour, so it interpolates against itself.
    assign idx      = bus.din[G_DWIDTH-1 -: G_ADDR_WIDTH];
    assign idx_ceil = (idx == TOP_IDX) ? idx : idx + G_ADDR_WIDTH'(1);
    assign prog_en  = bus.prog_we && !reset && (int'(bus.prog_ch) < G_CHANNELS);

    interp_lut_dpram #(
        .AW (RAW),
        .DW (G_DWIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (prog_en),
        .waddr   ({bus.prog_ch, bus.prog_addr}),
        .wdata   (bus.prog_data),
        .re      (advance),
        .raddr_a ({bus.din_ch, idx}),
        .raddr_b ({bus.din_ch, idx_ceil}),
        .rdata_a (floor_q),
        .rdata_b (ceil_q)
    );

    // Every stage, including the RAM read registers, advances together so a stall freezes the whole pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            m1           <= '0;
            m2           <= '0;
            m3           <= '0;
            m4           <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
        end else if (advance) begin
            m1.valid  <= bus.din_valid;
            m1.ch     <= MAX_CW'(bus.din_ch);
            m1.bypass <= bus.din_bypass;
            m1.frac   <= MAX_DW'(bus.din[F-1:0]);
            m1.raw    <= MAX_DW'(bus.din);

            m2     <= m1;
            floor2 <= ext(floor_q);
            diff2  <= ext(ceil_q) - ext(floor_q);

            m3     <= m2;
            floor3 <= floor2;
            prod3  <= PW'(diff2) * PW'($signed({1'b0, m2.frac[F-1:0]}));

            // Arithmetic shift floors toward -inf; the sum stays between floor and ceil.
            m4   <= m3;
            res4 <= G_DWIDTH'(PW'(floor3) + (prod3 >>> F));

            dout_valid_q <= m4.valid;
            dout_ch_q    <= m4.ch[CW-1:0];
            if (m4.bypass) begin
                dout_q <= m4.raw[G_DWIDTH-1:0];
            end else if (int'(m4.ch) >= G_CHANNELS) begin
                dout_q <= '0;
            end else begin
                dout_q <= res4;
            end
        end
    end

    assign unused_meta = ^m4;
endmodule

// File: tb/tb_interp_lut_stream.sv
// Scoreboard bench for interp_lut_stream: an unsigned and a signed instance, 4-bit index, 8-bit data.
// Stimulus pushes expected results; a negedge monitor pops and compares whenever an output transfers.
module tb_interp_lut_stream;

    typedef struct {
        logic [7:0] dout;
        logic       ch;
        int         acc;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   rand_ready = 1'b0;

    exp_t       q_u[$];
    exp_t       q_s[$];
    bit         held[2];
    logic [7:0] held_d[2];
    logic       held_c[2];
    int         tab_u[2][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    interp_lut_stream_if #(.ADDR_WIDTH(4), .DWIDTH(8), .CW(1)) bus_u ();
    interp_lut_stream_if #(.ADDR_WIDTH(4), .DWIDTH(8), .CW(1)) bus_s ();

    interp_lut_stream #(
        .G_ADDR_WIDTH (4),
        .G_DWIDTH     (8),
        .G_CHANNELS   (2),
        .G_SIGNED_DATA(0)
    ) dut_u (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_u)
    );

    interp_lut_stream #(
        .G_ADDR_WIDTH (4),
        .G_DWIDTH     (8),
        .G_CHANNELS   (2),
        .G_SIGNED_DATA(1)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Floor-division model of the interpolation on the unsigned instance's shadow tables.
    function automatic logic [7:0] ref_u(input int ch, input logic [7:0] d);
        int idx, fr, f, c, p, q;
        idx = int'(d[7:4]);
        fr  = int'(d[3:0]);
        f   = tab_u[ch][idx];
        c   = (idx == 15) ? f : tab_u[ch][idx + 1];
        p   = (c - f) * fr;
        q   = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        return 8'(f + q);
    endfunction

    task automatic prog_write(input bit sel, input logic ch, input logic [3:0] addr, input logic [7:0] data);
        if (sel) begin
            bus_s.prog_we = 1'b1; bus_s.prog_ch = ch; bus_s.prog_addr = addr; bus_s.prog_data = data;
        end else begin
            bus_u.prog_we = 1'b1; bus_u.prog_ch = ch; bus_u.prog_addr = addr; bus_u.prog_data = data;
            tab_u[int'(ch)][int'(addr)] = int'(data);
        end
        @(posedge clk); #1;
        bus_u.prog_we = 1'b0;
        bus_s.prog_we = 1'b0;
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] d, input logic ch, input logic byp,
                                 input logic [7:0] exp, input bit push, input bit lat);
        exp_t e;
        int   n;
        logic rdy;
        if (sel) begin
            bus_s.din = d; bus_s.din_ch = ch; bus_s.din_bypass = byp; bus_s.din_valid = 1'b1;
        end else begin
            bus_u.din = d; bus_u.din_ch = ch; bus_u.din_bypass = byp; bus_u.din_valid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            rdy = sel ? bus_s.din_ready : bus_u.din_ready;
        end while (!rdy && n < 1000);
        if (!rdy) checkOutput("din_ready_timeout", int'(rdy), 1);
        e.dout = exp; e.ch = ch; e.acc = cyc + 1; e.lat = lat;
        if (push) begin
            if (sel) q_s.push_back(e);
            else     q_u.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus_u.din_valid = 1'b0;
        bus_s.din_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_u.size() != 0 || q_s.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_u", q_u.size(), 0);
        checkOutput("drain_s", q_s.size(), 0);
    endtask

    task automatic observe(input bit sel);
        logic       v, r, c;
        logic [7:0] d;
        exp_t       e;
        string      p;
        p = sel ? "s" : "u";
        if (sel) begin
            v = bus_s.dout_valid; r = bus_s.dout_ready; d = bus_s.dout; c = bus_s.dout_ch;
        end else begin
            v = bus_u.dout_valid; r = bus_u.dout_ready; d = bus_u.dout; c = bus_u.dout_ch;
        end
        if (held[sel] && v) begin
            checkOutput({p, "_stall_dout"}, int'(d), int'(held_d[sel]));
            checkOutput({p, "_stall_ch"}, int'(c), int'(held_c[sel]));
        end
        held[sel]   = v && !r;
        held_d[sel] = d;
        held_c[sel] = c;
        if (v && r) begin
            if ((sel ? q_s.size() : q_u.size()) == 0) begin
                checkOutput({p, "_unexpected_valid"}, int'(v), 0);
            end else begin
                e = sel ? q_s.pop_front() : q_u.pop_front();
                checkOutput({p, "_dout"}, int'(d), int'(e.dout));
                checkOutput({p, "_dout_ch"}, int'(c), int'(e.ch));
                if (e.lat) checkOutput({p, "_latency"}, cyc - e.acc, 4);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        observe(1'b0);
        observe(1'b1);
    end

    // Downstream ready: steady high, or 30% low while random backpressure is enabled.
    initial forever begin
        @(posedge clk); #1;
        bus_u.dout_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0;
        reset = 1'b1;
        bus_u.prog_we = 1'b0; bus_u.prog_ch = 1'b0; bus_u.prog_addr = '0; bus_u.prog_data = '0;
        bus_u.din = '0; bus_u.din_ch = 1'b0; bus_u.din_bypass = 1'b0; bus_u.din_valid = 1'b0;
        bus_u.dout_ready = 1'b1;
        bus_s.prog_we = 1'b0; bus_s.prog_ch = 1'b0; bus_s.prog_addr = '0; bus_s.prog_data = '0;
        bus_s.din = '0; bus_s.din_ch = 1'b0; bus_s.din_bypass = 1'b0; bus_s.din_valid = 1'b0;
        bus_s.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_u_valid", int'(bus_u.dout_valid), 0);
        checkOutput("rst_u_dout", int'(bus_u.dout), 0);
        checkOutput("rst_u_ch", int'(bus_u.dout_ch), 0);
        checkOutput("rst_s_valid", int'(bus_s.dout_valid), 0);
        checkOutput("rst_s_dout", int'(bus_s.dout), 0);
        checkOutput("rst_s_ch", int'(bus_s.dout_ch), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            prog_write(1'b0, 1'b0, 4'(i), 8'(16 * i));
            prog_write(1'b0, 1'b1, 4'(i), 8'(255 - 16 * i));
        end
        prog_write(1'b1, 1'b0, 4'd0, 8'd10);
        prog_write(1'b1, 1'b0, 4'd1, 8'd9);

        // Unsigned ascending table, then top clamp and descending table on ch1.
        applyStimulus(1'b0, 8'h38, 1'b0, 1'b0, 8'd56, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h30, 1'b0, 1'b0, 8'd48, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h3F, 1'b0, 1'b0, 8'd63, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'hF7, 1'b0, 1'b0, 8'd240, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h18, 1'b1, 1'b0, 8'd231, 1'b1, 1'b1);
        idle();
        drain();

        // Signed tables: floor rounding, then an extreme span that must not overflow.
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 8'h09, 1'b1, 1'b1);
        idle();
        drain();
        prog_write(1'b1, 1'b0, 4'd0, 8'h80);
        prog_write(1'b1, 1'b0, 4'd1, 8'h7F);
        applyStimulus(1'b1, 8'h08, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
        idle();
        drain();

        // Full sweep under random backpressure, alternating channels.
        rand_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 8'(i), i[0], 1'b0, ref_u(i & 1, 8'(i)), 1'b1, 1'b0);
        end
        idle();
        rand_ready = 1'b0;
        drain();

        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'(i * 16 + 5), 1'b0, 1'b0, ref_u(0, 8'(i * 16 + 5)), 1'b1, 1'b1);
        end
        checkOutput("u_throughput", cyc - t0, 16);
        idle();
        drain();

        // Same-edge write and read of entry 3 sees the old value; later samples see the new one.
        bus_u.prog_we = 1'b1; bus_u.prog_ch = 1'b0; bus_u.prog_addr = 4'd3; bus_u.prog_data = 8'd100;
        applyStimulus(1'b0, 8'h30, 1'b0, 1'b0, 8'd48, 1'b1, 1'b1);
        bus_u.prog_we = 1'b0;
        tab_u[0][3] = 100;
        applyStimulus(1'b0, 8'h30, 1'b0, 1'b0, 8'd100, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h28, 1'b0, 1'b0, 8'd66, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
        idle();
        drain();

        // Reset with three samples in flight; a write attempted during reset must not land.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h11, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        end
        idle();
        reset = 1'b1;
        bus_u.prog_we = 1'b1; bus_u.prog_ch = 1'b0; bus_u.prog_addr = 4'd5; bus_u.prog_data = 8'hEE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus_u.prog_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("rst_flush_valid", int'(bus_u.dout_valid), 0);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h50, 1'b0, 1'b0, 8'd80, 1'b1, 1'b1);
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
